// File: rtl/booth_digit_decoder_acc.sv
// Radix-4 Booth digit decoder/accumulator: consumes (neg, two, one) digits LSB first,
// accumulates mcand x multiplier and rebuilds the multiplier from the digit stream.
module booth_digit_decoder_acc #(
    parameter int WIDTH    = 8,
    parameter int N_DIGITS = WIDTH / 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic                 dig_valid_i,
    output logic                 dig_ready_o,
    input  logic                 dig_neg_i,
    input  logic                 dig_two_i,
    input  logic                 dig_one_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic [WIDTH-1:0]     multiplier_o,
    output logic                 err_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(N_DIGITS) + 1;
    localparam int PW = WIDTH + 2;
    localparam int AW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] mult_q, mult_d;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    logic             mag1, mag2, illegal;
    logic             accept, last_digit;
    logic [CW:0]      shamt;
    logic [PW-1:0]    mcand_ext, pp_mag, pp;
    logic [AW-1:0]    pp_ext, acc_add;
    logic [WIDTH-1:0] d_mag, d_val, mult_add;

    assign illegal    = dig_two_i & dig_one_i;
    assign mag1       = dig_one_i & ~dig_two_i;
    assign mag2       = dig_two_i & ~dig_one_i;
    assign accept     = dig_valid_i && (state_q == S_ACCUM);
    assign last_digit = (count_q == CW'(N_DIGITS - 1));
    assign shamt      = {count_q, 1'b0};

    // Partial product formed at WIDTH+2 bits so +/-2*mcand never overflows before the shift.
    always_comb begin
        mcand_ext = {{2{mcand_q[WIDTH-1]}}, mcand_q};
        pp_mag    = '0;
        if (mag1) begin
            pp_mag = mcand_ext;
        end else if (mag2) begin
            pp_mag = mcand_ext << 1;
        end
        pp      = dig_neg_i ? -pp_mag : pp_mag;
        pp_ext  = {{(AW - PW){pp[PW-1]}}, pp};
        acc_add = pp_ext << shamt;
    end

    always_comb begin
        d_mag = '0;
        if (mag1) begin
            d_mag = WIDTH'(1);
        end else if (mag2) begin
            d_mag = WIDTH'(2);
        end
        d_val    = dig_neg_i ? -d_mag : d_mag;
        mult_add = d_val << shamt;
    end

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        mult_d  = mult_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mcand_d = mcand_i;
                    acc_d   = '0;
                    mult_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d   = acc_q + acc_add;
                    mult_d  = mult_q + mult_add;
                    count_d = count_q + CW'(1);
                    err_d   = err_q | illegal;
                    if (last_digit) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            mult_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            mult_q  <= mult_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign dig_ready_o  = (state_q == S_ACCUM);
    assign out_valid_o  = (state_q == S_DONE);
    assign busy_o       = (state_q != S_IDLE);
    assign product_o    = acc_q;
    assign multiplier_o = mult_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_booth_digit_decoder_acc.sv
// Directed-vector bench for booth_digit_decoder_acc (WIDTH=8, four digits per operation).
module tb_booth_digit_decoder_acc;

    logic        clk = 1'b0;
    logic        rst, start, dig_valid, dig_neg, dig_two, dig_one, out_ready;
    logic [7:0]  mcand;
    logic        dig_ready, out_valid, err, busy;
    logic [15:0] product;
    logic [7:0]  multiplier;

    int tests = 0;
    int fails = 0;

    booth_digit_decoder_acc #(.WIDTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mcand_i(mcand),
        .dig_valid_i(dig_valid), .dig_ready_o(dig_ready),
        .dig_neg_i(dig_neg), .dig_two_i(dig_two), .dig_one_i(dig_one),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .product_o(product), .multiplier_o(multiplier),
        .err_o(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts an operation and feeds the digits ({neg,two,one} per 3 bits, LSB digit first).
    // lat = cycles from the start cycle until out_valid is seen; 99 if it never arrives.
    task automatic run_op(input logic [7:0] mc, input logic [11:0] digs, input bit gaps,
                          output int lat);
        int  idx;
        bit  phase;
        bit  took;
        logic [2:0] trip;
        start = 1'b1;
        mcand = mc;
        tick();
        start = 1'b0;
        lat   = 1;
        idx   = 0;
        phase = 1'b1;
        while (!out_valid && lat < 40) begin
            took = 1'b0;
            if (idx < 4 && phase) begin
                trip = digs[idx*3 +: 3];
                {dig_neg, dig_two, dig_one} = trip;
                dig_valid = 1'b1;
                took = dig_ready;
            end else begin
                dig_valid = 1'b0;
            end
            if (gaps) phase = ~phase;
            tick();
            if (took) idx++;
            lat++;
        end
        dig_valid = 1'b0;
        {dig_neg, dig_two, dig_one} = 3'b000;
        if (!out_valid) lat = 99;
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if ({dig_ready, out_valid, busy, err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got=%b exp=0000", {dig_ready, out_valid, busy, err});
        end
        tests++;
        if (product !== 16'h0000 || multiplier !== 8'h00) begin
            fails++;
            $display("FAIL reset_data got=%h/%h exp=0000/00", product, multiplier);
        end
    endtask

    task automatic test_basic(input bit gaps, input int exp_lat);
        int lat;
        run_op(8'd7, {3'b000, 3'b000, 3'b001, 3'b101}, gaps, lat);
        tests++;
        if (lat !== exp_lat) begin
            fails++;
            $display("FAIL basic_latency gaps=%0d got=%0d exp=%0d", gaps, lat, exp_lat);
        end
        tests++;
        if (multiplier !== 8'd3 || product !== 16'h0015 || err !== 1'b0) begin
            fails++;
            $display("FAIL basic_result got=%h/%h/%b exp=03/0015/0", multiplier, product, err);
        end
    endtask

    task automatic test_min_mcand();
        int lat;
        run_op(8'h80, {3'b110, 3'b000, 3'b000, 3'b000}, 1'b0, lat);
        tests++;
        if (lat !== 5 || multiplier !== 8'h80 || product !== 16'h4000) begin
            fails++;
            $display("FAIL min_mcand got=%0d/%h/%h exp=5/80/4000", lat, multiplier, product);
        end
        finish_op();
    endtask

    task automatic test_neg_zero();
        int lat;
        run_op(8'd127, {3'b100, 3'b100, 3'b100, 3'b101}, 1'b0, lat);
        tests++;
        if (lat !== 5 || multiplier !== 8'hFF || product !== 16'hFF81 || err !== 1'b0) begin
            fails++;
            $display("FAIL neg_zero got=%0d/%h/%h/%b exp=5/ff/ff81/0", lat, multiplier, product, err);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        test_basic(1'b0, 5);
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b0;
            start     = 1'b1;
            mcand     = 8'h55;
            dig_valid = 1'b1;
            {dig_neg, dig_two, dig_one} = 3'b001;
            tick();
            tests++;
            if (out_valid !== 1'b1 || dig_ready !== 1'b0 || busy !== 1'b1 ||
                product !== 16'h0015 || multiplier !== 8'd3) begin
                fails++;
                $display("FAIL hold_cycle%0d got=%b%b%b/%h/%h exp=101/0015/03", i,
                         out_valid, dig_ready, busy, product, multiplier);
            end
        end
        start     = 1'b0;
        dig_valid = 1'b0;
        {dig_neg, dig_two, dig_one} = 3'b000;
        finish_op();
        tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || product !== 16'h0015 || multiplier !== 8'd3) begin
            fails++;
            $display("FAIL release_idle got=%b%b/%h/%h exp=00/0015/03", busy, out_valid, product, multiplier);
        end
        test_min_mcand();
    endtask

    task automatic test_illegal();
        int lat;
        run_op(8'd5, {3'b000, 3'b000, 3'b001, 3'b011}, 1'b0, lat);
        tests++;
        if (lat !== 5 || err !== 1'b1 || multiplier !== 8'd4 || product !== 16'd20) begin
            fails++;
            $display("FAIL illegal got=%0d/%b/%h/%h exp=5/1/04/0014", lat, err, multiplier, product);
        end
        finish_op();
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL illegal_err_kept got=%b exp=1", err);
        end
        test_basic(1'b0, 5);
        finish_op();
    endtask

    task automatic test_reset_mid_and_gaps();
        start = 1'b1;
        mcand = 8'd5;
        tick();
        start = 1'b0;
        dig_valid = 1'b1;
        {dig_neg, dig_two, dig_one} = 3'b011;
        tick();
        {dig_neg, dig_two, dig_one} = 3'b001;
        tick();
        dig_valid = 1'b0;
        {dig_neg, dig_two, dig_one} = 3'b000;
        tests++;
        if (product !== 16'd20 || multiplier !== 8'd4 || err !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL partial got=%h/%h/%b/%b exp=0014/04/1/1", product, multiplier, err, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({dig_ready, out_valid, busy, err} !== 4'b0000 || product !== 16'h0 || multiplier !== 8'h0) begin
            fails++;
            $display("FAIL reset_mid got=%b/%h/%h exp=0000/0000/00",
                     {dig_ready, out_valid, busy, err}, product, multiplier);
        end
        test_basic(1'b1, 8);
        finish_op();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mcand = '0; dig_valid = 1'b0;
        dig_neg = 1'b0; dig_two = 1'b0; dig_one = 1'b0; out_ready = 1'b0;
        test_reset();
        test_basic(1'b0, 5);
        finish_op();
        test_neg_zero();
        test_backpressure();
        test_illegal();
        test_reset_mid_and_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/booth_digit_decoder_acc.md
# booth_digit_decoder_acc

Sequential radix-4 Booth decoder/accumulator for the MACC datapath: the receiving end of the Booth encoder. It accepts one encoded Booth digit per handshake, least-significant digit first, as the (neg, two, one) triplet the encoder produces. It applies each digit to a latched signed multiplicand, accumulates the shifted partial products into a full-width signed product, and also reconstructs the original multiplier value from the digit stream. The result is presented on a valid/ready output port.

## Interface
- WIDTH, 8: multiplicand/multiplier width in bits (signed, two's complement); must be even, ≥4
- N_DIGITS, WIDTH/2: Booth digits per operation (derived; not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin operation; sampled only in IDLE
- mcand  in  WIDTH  signed multiplicand; captured on accepted start
- dig_valid  in  1  digit triplet valid
- dig_ready  out  1  block accepts a digit
- dig_neg  in  1  encoder P2: digit sign
- dig_two  in  1  encoder P1: magnitude 2
- dig_one  in  1  encoder P0: magnitude 1
- out_valid  out  1  product/multiplier valid
- out_ready  in  1  consumer accepts result
- product  out  2*WIDTH  signed mcand × reconstructed multiplier
- multiplier  out  WIDTH  reconstructed multiplier, Σ d_i·4^i truncated to WIDTH bits
- err  out  1  an illegal digit (two=1 and one=1) was received in this operation
- busy  out  1  state ≠ IDLE

## Operation
- Digit value d: one=1 gives ±1; two=1 gives ±2; both 0 gives 0. Sign is negative when neg=1. neg=1 with zero magnitude gives 0.
- Illegal code (two=1 and one=1): treated as d=0 and still counted as a digit. Sets err, which stays set until the next accepted start.
- States: IDLE, ACCUM, DONE.
  - IDLE: dig_ready=0, out_valid=0. On start=1: latch mcand, clear acc, mult, count and err, then go to ACCUM.
  - ACCUM: dig_ready=1. On dig_valid∧dig_ready:
    - acc ← acc + sext(d·mcand) << 2·count, computed at 2*WIDTH bits with wrap.
    - mult ← mult + d << 2·count, at WIDTH bits with wrap.
    - count++.
    - If this digit is digit N_DIGITS−1, go to DONE.
  - DONE: out_valid=1, dig_ready=0. product, multiplier and err are held stable. On out_ready=1, go to IDLE.
- start is ignored outside IDLE. dig_valid is ignored outside ACCUM.
- d·mcand is computed at WIDTH+2 bits before sign extension, so no overflow occurs before the shift.

## Timing
- Reset values: state=IDLE; dig_ready=0; out_valid=0; busy=0; err=0; product=0; multiplier=0; count=0.
- Reset overrides everything, including mid-ACCUM and DONE. Partial results are discarded.
- start accepted in cycle t: busy=1 and dig_ready=1 in cycle t+1.
- With digits back-to-back, the last digit is accepted in cycle t+N_DIGITS and out_valid=1 in cycle t+N_DIGITS+1. Gaps in dig_valid stretch the latency 1:1.
- Result handshake in cycle u (out_valid∧out_ready): state=IDLE in u+1. A start in u+1 is accepted, so the minimum period is N_DIGITS+2 cycles.
- product, multiplier and err are registered; they change only on digit acceptance and on start.
- product and multiplier keep the completed values in IDLE until the next start.

## Test plan
- mcand=7; digits (LSB first) 3:
  - Stimulus: (neg,two,one) = 101, 001, 000, 000 → −1, +1, 0, 0.
  - Response: multiplier=3; product=21 (0x0015); err=0; out_valid exactly 5 cycles after the start cycle.
- mcand=−128; digits 000, 000, 000, 110 (0, 0, 0, −2):
  - Response: multiplier=0x80 (−128); product=0x4000 (16384).
- mcand=127; digits 101, 100, 100, 100 (−1 then three negative zeros):
  - Response: multiplier=0xFF (−1); product=0xFF81 (−127).
- Backpressure:
  - Stimulus: at DONE, hold out_ready=0 for 5 cycles; pulse start and dig_valid during those cycles.
  - Response: outputs stable; dig_ready=0; start ignored. After out_ready=1, IDLE next cycle; a new start then works.
- Illegal digit:
  - Stimulus: mcand=5; digits 011, 001, 000, 000.
  - Response: err=1; multiplier=4; product=20. A following clean operation shows err=0.
- Reset mid-operation and gaps:
  - Stimulus: assert rst after 2 digits.
  - Response: next cycle all outputs at reset values.
  - Then: rerun the first test with dig_valid low on alternate cycles. Response: same result, with out_valid 3 cycles later than back-to-back.
